// File: rtl/bomb_manager.sv
// Bomb lifecycle engine: per-player bomb slots, tick-driven fuses, one explosion per cycle.
// Optional chain reactions are enabled by defining BOMB_CHAIN_EN.
module bomb_manager #(
  parameter int SLOTS_PER_PLAYER = 4,
  parameter int FUSE_TICKS       = 3,
  parameter int CHAIN_RANGE      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         p1_set_bomb,
  input  logic [3:0]   p1_x,
  input  logic [3:0]   p1_y,
  input  logic         p2_set_bomb,
  input  logic [3:0]   p2_x,
  input  logic [3:0]   p2_y,
  output logic [2:0]   bomb_num_1,
  output logic [2:0]   bomb_num_2,
  output logic [255:0] bomb_map,
  output logic         place_reject_1,
  output logic         place_reject_2,
  output logic         explode_valid,
  output logic [3:0]   explode_x,
  output logic [3:0]   explode_y,
  output logic         explode_owner
);

  localparam int S  = SLOTS_PER_PLAYER;
  localparam int NS = 2 * S;
  localparam int IW = $clog2(NS);

  if (S < 1 || S > 7 || FUSE_TICKS < 1 || FUSE_TICKS > 15 ||
      CHAIN_RANGE < 1 || CHAIN_RANGE > 15) begin : g_bad_param
    $error("bomb_manager: parameter out of legal range");
  end

  logic [NS-1:0]  valid_q, ripe_q;
  logic [3:0]     x_q [NS];
  logic [3:0]     y_q [NS];

  logic           ret_any, ret_owner;
  logic [IW-1:0]  ret_idx;
  logic [3:0]     ret_x, ret_y;
  logic           p1_free, p2_free, p1_acc, p2_acc;
  logic [IW-1:0]  p1_idx, p2_idx;

  logic [255:0]   bomb_map_q, bomb_map_d;
  logic [2:0]     num1_q, num1_d, num2_q, num2_d;
  logic           rej1_q, rej2_q, exp_valid_q, exp_owner_q;
  logic [3:0]     exp_x_q, exp_y_q;

  // Descending scans leave the lowest-index match in each result.
  always_comb begin
    ret_any = 1'b0;
    ret_idx = '0;
    p1_free = 1'b0;
    p1_idx  = '0;
    p2_free = 1'b0;
    p2_idx  = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (ripe_q[i]) begin
        ret_any = 1'b1;
        ret_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        if (i < S) begin
          p1_free = 1'b1;
          p1_idx  = IW'(i);
        end else begin
          p2_free = 1'b1;
          p2_idx  = IW'(i);
        end
      end
    end
  end

  assign ret_x     = x_q[ret_idx];
  assign ret_y     = y_q[ret_idx];
  assign ret_owner = (ret_idx >= IW'(S));

  // The map still shows a bomb retiring this cycle, so its cell stays blocked.
  assign p1_acc = p1_set_bomb && p1_free && !bomb_map_q[{p1_y, p1_x}];
  assign p2_acc = p2_set_bomb && p2_free && !bomb_map_q[{p2_y, p2_x}] &&
                  !(p1_acc && (p1_x == p2_x) && (p1_y == p2_y));

  for (genvar gi = 0; gi < NS; gi++) begin : g_slot
    logic       v_q, v_d, r_q, r_d;
    logic [3:0] sx_q, sx_d, sy_q, sy_d, f_q, f_d;
    logic       load, retire, chain_hit;

    assign load   = (p1_acc && (p1_idx == IW'(gi))) || (p2_acc && (p2_idx == IW'(gi)));
    assign retire = ret_any && (ret_idx == IW'(gi));

`ifdef BOMB_CHAIN_EN
    logic [3:0] dx, dy;
    assign dx = (sx_q >= ret_x) ? (sx_q - ret_x) : (ret_x - sx_q);
    assign dy = (sy_q >= ret_y) ? (sy_q - ret_y) : (ret_y - sy_q);
    assign chain_hit = ret_any && !retire && v_q &&
                       (((sy_q == ret_y) && (dx <= 4'(CHAIN_RANGE))) ||
                        ((sx_q == ret_x) && (dy <= 4'(CHAIN_RANGE))));
`else
    assign chain_hit = 1'b0;
`endif

    always_comb begin
      v_d  = v_q;
      r_d  = r_q;
      sx_d = sx_q;
      sy_d = sy_q;
      f_d  = f_q;
      if (retire) begin
        v_d = 1'b0;
        r_d = 1'b0;
      end else if (load) begin
        v_d  = 1'b1;
        r_d  = 1'b0;
        sx_d = (gi < S) ? p1_x : p2_x;
        sy_d = (gi < S) ? p1_y : p2_y;
        f_d  = 4'(FUSE_TICKS);
      end else if (chain_hit) begin
        r_d = 1'b1;
        f_d = 4'd0;
      end else if (tick && v_q && !r_q && (f_q != 4'd0)) begin
        f_d = f_q - 4'd1;
        if (f_q == 4'd1) r_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        r_q  <= 1'b0;
        sx_q <= '0;
        sy_q <= '0;
        f_q  <= '0;
      end else begin
        v_q  <= v_d;
        r_q  <= r_d;
        sx_q <= sx_d;
        sy_q <= sy_d;
        f_q  <= f_d;
      end
    end

    assign valid_q[gi] = v_q;
    assign ripe_q[gi]  = r_q;
    assign x_q[gi]     = sx_q;
    assign y_q[gi]     = sy_q;
  end

  always_comb begin
    bomb_map_d = bomb_map_q;
    if (ret_any) bomb_map_d[{ret_y, ret_x}] = 1'b0;
    if (p1_acc)  bomb_map_d[{p1_y, p1_x}]   = 1'b1;
    if (p2_acc)  bomb_map_d[{p2_y, p2_x}]   = 1'b1;
  end

  assign num1_d = num1_q + {2'b00, p1_acc} - {2'b00, ret_any && !ret_owner};
  assign num2_d = num2_q + {2'b00, p2_acc} - {2'b00, ret_any && ret_owner};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bomb_map_q  <= '0;
      num1_q      <= '0;
      num2_q      <= '0;
      rej1_q      <= 1'b0;
      rej2_q      <= 1'b0;
      exp_valid_q <= 1'b0;
      exp_x_q     <= '0;
      exp_y_q     <= '0;
      exp_owner_q <= 1'b0;
    end else begin
      bomb_map_q  <= bomb_map_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      rej1_q      <= p1_set_bomb && !p1_acc;
      rej2_q      <= p2_set_bomb && !p2_acc;
      exp_valid_q <= ret_any;
      if (ret_any) begin
        exp_x_q     <= ret_x;
        exp_y_q     <= ret_y;
        exp_owner_q <= ret_owner;
      end
    end
  end

  assign bomb_map       = bomb_map_q;
  assign bomb_num_1     = num1_q;
  assign bomb_num_2     = num2_q;
  assign place_reject_1 = rej1_q;
  assign place_reject_2 = rej2_q;
  assign explode_valid  = exp_valid_q;
  assign explode_x      = exp_x_q;
  assign explode_y      = exp_y_q;
  assign explode_owner  = exp_owner_q;

endmodule
